// File: rtl/mailbox_write_arbiter_pkg.sv
// Shared types and constants for the two-master mailbox write arbiter.
package mailbox_write_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_AW    = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef logic mst_idx_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A lone requester always wins; a tie goes to the priority holder.
  function automatic mst_idx_t rr_pick(input logic [1:0] req, input mst_idx_t prio);
    return (&req) ? prio : req[1];
  endfunction

endpackage

// File: rtl/mailbox_write_arbiter_rr.sv
// Two-way round-robin grant selection with the priority register it owns.
module mailbox_write_arbiter_rr
  import mailbox_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       prio_upd,
  input  logic       prio_next,
  output logic       grant,
  output logic       prio
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (prio_upd) begin
      prio <= prio_next;
    end
  end

  assign grant = rr_pick(req, prio);

endmodule

// File: rtl/mailbox_write_arbiter.sv
// Transaction-level round-robin arbiter sharing one AXI4 write port between two masters.
// Optional grant counters are built when MAILBOX_WRITE_ARBITER_PERF_EN is defined.
module mailbox_write_arbiter
  import mailbox_write_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic [AXI_ADDR_WIDTH-1:0] S0_AwAddr_DI,
  input  logic [7:0]                S0_AwLen_SI,
  input  logic [AXI_ID_WIDTH-1:0]   S0_AwId_DI,
  input  logic                      S0_AwValid_SI,
  output logic                      S0_AwReady_SO,
  input  logic [AXI_DATA_WIDTH-1:0] S0_WData_DI,
  input  logic [AXI_STRB_WIDTH-1:0] S0_WStrb_DI,
  input  logic                      S0_WLast_SI,
  input  logic                      S0_WValid_SI,
  output logic                      S0_WReady_SO,
  output logic                      S0_BValid_SO,
  input  logic                      S0_BReady_SI,
  output logic [AXI_ID_WIDTH-1:0]   S0_BId_DO,
  output logic [1:0]                S0_BResp_DO,
  output logic [AXI_USER_WIDTH-1:0] S0_BUser_DO,
  input  logic [AXI_ADDR_WIDTH-1:0] S1_AwAddr_DI,
  input  logic [7:0]                S1_AwLen_SI,
  input  logic [AXI_ID_WIDTH-1:0]   S1_AwId_DI,
  input  logic                      S1_AwValid_SI,
  output logic                      S1_AwReady_SO,
  input  logic [AXI_DATA_WIDTH-1:0] S1_WData_DI,
  input  logic [AXI_STRB_WIDTH-1:0] S1_WStrb_DI,
  input  logic                      S1_WLast_SI,
  input  logic                      S1_WValid_SI,
  output logic                      S1_WReady_SO,
  output logic                      S1_BValid_SO,
  input  logic                      S1_BReady_SI,
  output logic [AXI_ID_WIDTH-1:0]   S1_BId_DO,
  output logic [1:0]                S1_BResp_DO,
  output logic [AXI_USER_WIDTH-1:0] S1_BUser_DO,
  output logic [AXI_ADDR_WIDTH-1:0] M_AwAddr_DO,
  output logic [7:0]                M_AwLen_SO,
  output logic [AXI_ID_WIDTH-1:0]   M_AwId_DO,
  output logic                      M_AwValid_SO,
  input  logic                      M_AwReady_SI,
  output logic [AXI_DATA_WIDTH-1:0] M_WData_DO,
  output logic [AXI_STRB_WIDTH-1:0] M_WStrb_DO,
  output logic                      M_WLast_SO,
  output logic                      M_WValid_SO,
  input  logic                      M_WReady_SI,
  input  logic                      M_BValid_SI,
  input  logic [AXI_ID_WIDTH-1:0]   M_BId_DI,
  input  logic [1:0]                M_BResp_DI,
  input  logic [AXI_USER_WIDTH-1:0] M_BUser_DI,
`ifdef MAILBOX_WRITE_ARBITER_PERF_EN
  output logic [31:0]               GrantCnt0_DO,
  output logic [31:0]               GrantCnt1_DO,
`endif
  output logic                      M_BReady_SO
);

  state_t     state;
  mst_idx_t   grant;
  logic [7:0] beat_cnt;
  mst_idx_t   rr_grant;
  mst_idx_t   prio;
  logic       aw_hs, w_hs, b_hs;
  logic       in_aw, in_w, in_b;
  logic       b_valid_fwd;

  logic [AXI_ADDR_WIDTH-1:0] sel_awaddr;
  logic [7:0]                sel_awlen;
  logic [AXI_ID_WIDTH-1:0]   sel_awid;
  logic                      sel_awvalid;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;
  logic [AXI_STRB_WIDTH-1:0] sel_wstrb;
  logic                      sel_wlast;
  logic                      sel_wvalid;
  logic                      sel_bready;

  mailbox_write_arbiter_rr u_rr (
    .clk       (Clk_CI),
    .rst       (Rst_RI),
    .req       ({S1_AwValid_SI, S0_AwValid_SI}),
    .prio_upd  (b_hs),
    .prio_next (~grant),
    .grant     (rr_grant),
    .prio      (prio)
  );

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state    <= ST_IDLE;
      grant    <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S0_AwValid_SI || S1_AwValid_SI) begin
            grant <= rr_grant;
            state <= ST_AW;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            beat_cnt <= sel_awlen;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The beat counter alone ends the burst; WLast is only forwarded.
          if (w_hs) begin
            if (beat_cnt == 8'd0) state <= ST_RESP;
            else                  beat_cnt <= beat_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (b_hs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_aw = (state == ST_AW);
  assign in_w  = (state == ST_WRITE);
  assign in_b  = (state == ST_RESP);

  assign sel_awaddr  = grant ? S1_AwAddr_DI  : S0_AwAddr_DI;
  assign sel_awlen   = grant ? S1_AwLen_SI   : S0_AwLen_SI;
  assign sel_awid    = grant ? S1_AwId_DI    : S0_AwId_DI;
  assign sel_awvalid = grant ? S1_AwValid_SI : S0_AwValid_SI;
  assign sel_wdata   = grant ? S1_WData_DI   : S0_WData_DI;
  assign sel_wstrb   = grant ? S1_WStrb_DI   : S0_WStrb_DI;
  assign sel_wlast   = grant ? S1_WLast_SI   : S0_WLast_SI;
  assign sel_wvalid  = grant ? S1_WValid_SI  : S0_WValid_SI;
  assign sel_bready  = grant ? S1_BReady_SI  : S0_BReady_SI;

  // Downstream valids depend only on state and master inputs, never on downstream readies.
  assign M_AwValid_SO = in_aw & sel_awvalid;
  assign M_AwAddr_DO  = M_AwValid_SO ? sel_awaddr : '0;
  assign M_AwLen_SO   = M_AwValid_SO ? sel_awlen  : '0;
  assign M_AwId_DO    = M_AwValid_SO ? sel_awid   : '0;
  assign aw_hs        = M_AwValid_SO & M_AwReady_SI;

  assign M_WValid_SO = in_w & sel_wvalid;
  assign M_WData_DO  = M_WValid_SO ? sel_wdata : '0;
  assign M_WStrb_DO  = M_WValid_SO ? sel_wstrb : '0;
  assign M_WLast_SO  = M_WValid_SO & sel_wlast;
  assign w_hs        = M_WValid_SO & M_WReady_SI;

  assign S0_AwReady_SO = in_aw & ~grant & M_AwReady_SI;
  assign S1_AwReady_SO = in_aw &  grant & M_AwReady_SI;
  assign S0_WReady_SO  = in_w  & ~grant & M_WReady_SI;
  assign S1_WReady_SO  = in_w  &  grant & M_WReady_SI;

  assign M_BReady_SO = in_b & sel_bready;
  assign b_valid_fwd = in_b & M_BValid_SI;
  assign b_hs        = b_valid_fwd & M_BReady_SO;

  assign S0_BValid_SO = b_valid_fwd & ~grant;
  assign S0_BId_DO    = S0_BValid_SO ? M_BId_DI   : '0;
  assign S0_BResp_DO  = S0_BValid_SO ? M_BResp_DI : RESP_OKAY;
  assign S0_BUser_DO  = S0_BValid_SO ? M_BUser_DI : '0;
  assign S1_BValid_SO = b_valid_fwd & grant;
  assign S1_BId_DO    = S1_BValid_SO ? M_BId_DI   : '0;
  assign S1_BResp_DO  = S1_BValid_SO ? M_BResp_DI : RESP_OKAY;
  assign S1_BUser_DO  = S1_BValid_SO ? M_BUser_DI : '0;

`ifdef MAILBOX_WRITE_ARBITER_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      grant_cnt0 <= 32'd0;
      grant_cnt1 <= 32'd0;
    end else if (b_hs) begin
      if (!grant && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (grant && grant_cnt1 != 32'hFFFF_FFFF)  grant_cnt1 <= grant_cnt1 + 32'd1;
    end
  end

  assign GrantCnt0_DO = grant_cnt0;
  assign GrantCnt1_DO = grant_cnt1;
`endif

endmodule

// File: tb/tb_mailbox_write_arbiter.sv
// Directed transaction-table bench for mailbox_write_arbiter, bench acting as both masters and the slave.
module tb_mailbox_write_arbiter;
  import mailbox_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_awaddr [2];
  logic [7:0]  s_awlen  [2];
  logic [9:0]  s_awid   [2];
  logic [63:0] s_wdata  [2];
  logic [7:0]  s_wstrb  [2];
  logic [9:0]  s_bid    [2];
  logic [1:0]  s_bresp  [2];
  logic [5:0]  s_buser  [2];
  logic [1:0]  s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [9:0]  m_awid;
  logic        m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;
  logic [9:0]  m_bid;
  logic [1:0]  m_bresp;
  logic [5:0]  m_buser;
`ifdef MAILBOX_WRITE_ARBITER_PERF_EN
  logic [31:0] cnt0, cnt1;
`endif

  mailbox_write_arbiter dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .S0_AwAddr_DI(s_awaddr[0]), .S0_AwLen_SI(s_awlen[0]), .S0_AwId_DI(s_awid[0]),
    .S0_AwValid_SI(s_awvalid[0]), .S0_AwReady_SO(s_awready[0]),
    .S0_WData_DI(s_wdata[0]), .S0_WStrb_DI(s_wstrb[0]), .S0_WLast_SI(s_wlast[0]),
    .S0_WValid_SI(s_wvalid[0]), .S0_WReady_SO(s_wready[0]),
    .S0_BValid_SO(s_bvalid[0]), .S0_BReady_SI(s_bready[0]), .S0_BId_DO(s_bid[0]),
    .S0_BResp_DO(s_bresp[0]), .S0_BUser_DO(s_buser[0]),
    .S1_AwAddr_DI(s_awaddr[1]), .S1_AwLen_SI(s_awlen[1]), .S1_AwId_DI(s_awid[1]),
    .S1_AwValid_SI(s_awvalid[1]), .S1_AwReady_SO(s_awready[1]),
    .S1_WData_DI(s_wdata[1]), .S1_WStrb_DI(s_wstrb[1]), .S1_WLast_SI(s_wlast[1]),
    .S1_WValid_SI(s_wvalid[1]), .S1_WReady_SO(s_wready[1]),
    .S1_BValid_SO(s_bvalid[1]), .S1_BReady_SI(s_bready[1]), .S1_BId_DO(s_bid[1]),
    .S1_BResp_DO(s_bresp[1]), .S1_BUser_DO(s_buser[1]),
    .M_AwAddr_DO(m_awaddr), .M_AwLen_SO(m_awlen), .M_AwId_DO(m_awid),
    .M_AwValid_SO(m_awvalid), .M_AwReady_SI(m_awready),
    .M_WData_DO(m_wdata), .M_WStrb_DO(m_wstrb), .M_WLast_SO(m_wlast),
    .M_WValid_SO(m_wvalid), .M_WReady_SI(m_wready),
    .M_BValid_SI(m_bvalid), .M_BId_DI(m_bid), .M_BResp_DI(m_bresp), .M_BUser_DI(m_buser),
`ifdef MAILBOX_WRITE_ARBITER_PERF_EN
    .GrantCnt0_DO(cnt0), .GrantCnt1_DO(cnt1),
`endif
    .M_BReady_SO(m_bready)
  );

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [9:0]  id;
    logic [7:0]  strb;
    logic [1:0]  bresp;
    int          bstall;
    logic        wtoggle;
    int          exp_g;
  } vec_t;

  vec_t vecs [14];
  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt [2];

  function automatic vec_t mk(input logic [1:0] req, input logic [7:0] len, input logic [31:0] addr,
                              input logic [9:0] id, input logic [7:0] strb, input logic [1:0] bresp,
                              input int bstall, input logic wtoggle, input int exp_g);
    vec_t v;
    v.req = req; v.len = len; v.addr = addr; v.id = id; v.strb = strb;
    v.bresp = bresp; v.bstall = bstall; v.wtoggle = wtoggle; v.exp_g = exp_g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      s_awaddr[m] = '0; s_awlen[m] = '0; s_awid[m] = '0;
      s_wdata[m] = '0; s_wstrb[m] = '0;
    end
    s_awvalid = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_bid = '0; m_bresp = '0; m_buser = '0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int g, o, beat, cyc;
    g = v.exp_g;
    o = 1 - g;
    for (int m = 0; m < 2; m++) begin
      s_awvalid[m] = v.req[m];
      s_awaddr[m]  = v.addr + (m == 1 ? 32'h0001_0000 : 32'h0);
      s_awid[m]    = v.id + 10'(m);
      s_awlen[m]   = (m == g) ? v.len : (v.len ^ 8'h10);
    end
    #1;
    chk("idle_no_aw", {63'd0, m_awvalid}, 64'd0);
    step();
    chk("aw_valid", {63'd0, m_awvalid}, 64'd1);
    chk("aw_addr", {32'd0, m_awaddr}, {32'd0, v.addr + (g == 1 ? 32'h0001_0000 : 32'h0)});
    chk("aw_id", {54'd0, m_awid}, {54'd0, v.id + 10'(g)});
    chk("aw_len", {56'd0, m_awlen}, {56'd0, v.len});
    m_awready = 1'b1;
    #1;
    chk("aw_ready_grant", {63'd0, s_awready[g]}, 64'd1);
    chk("aw_ready_other", {63'd0, s_awready[o]}, 64'd0);
    step();
    s_awvalid = '0;
    m_awready = 1'b0;
    s_wvalid[o] = 1'b1;
    s_wdata[o]  = 64'hBAD0_BAD0_BAD0_BAD0;
    s_wlast[o]  = 1'b1;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(v.len) && cyc < 64) begin
      s_wvalid[g] = 1'b1;
      s_wdata[g]  = {32'(idx), 32'(beat)};
      s_wstrb[g]  = v.strb;
      s_wlast[g]  = (beat == int'(v.len));
      m_wready    = v.wtoggle ? cyc[0] : 1'b1;
      #1;
      chk("w_valid", {63'd0, m_wvalid}, 64'd1);
      chk("w_data", m_wdata, {32'(idx), 32'(beat)});
      chk("w_strb", {56'd0, m_wstrb}, {56'd0, v.strb});
      chk("w_last", {63'd0, m_wlast}, {63'd0, beat == int'(v.len)});
      chk("w_ready_grant", {63'd0, s_wready[g]}, {63'd0, m_wready});
      chk("w_ready_other", {63'd0, s_wready[o]}, 64'd0);
      if (m_wready) beat++;
      cyc++;
      step();
    end
    chk("w_beats", 64'(beat), 64'(int'(v.len) + 1));
    s_wdata[g] = {32'(idx), 32'(beat)};
    #1;
    chk("w_stop_after_last", {63'd0, m_wvalid}, 64'd0);
    s_wvalid = '0;
    s_wlast  = '0;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bid    = v.id + 10'(g);
    m_bresp  = v.bresp;
    m_buser  = 6'(idx);
    for (int k = 0; k < v.bstall; k++) begin
      #1;
      chk("b_ready_held", {63'd0, m_bready}, 64'd0);
      chk("b_valid_held", {63'd0, s_bvalid[g]}, 64'd1);
      step();
    end
    s_bready = 2'b11;
    #1;
    chk("b_ready", {63'd0, m_bready}, 64'd1);
    chk("b_valid_grant", {63'd0, s_bvalid[g]}, 64'd1);
    chk("b_valid_other", {63'd0, s_bvalid[o]}, 64'd0);
    chk("b_id_other", {54'd0, s_bid[o]}, 64'd0);
    chk("b_id", {54'd0, s_bid[g]}, {54'd0, v.id + 10'(g)});
    chk("b_resp", {62'd0, s_bresp[g]}, {62'd0, v.bresp});
    chk("b_user", {58'd0, s_buser[g]}, {58'd0, 6'(idx)});
    step();
    chk("b_back_to_idle", {63'd0, s_bvalid[g]}, 64'd0);
    m_bvalid = 1'b0;
    s_bready = '0;
    exp_cnt[g]++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(2'b11, 8'd0, 32'h0000_1000, 10'h011, 8'hFF, RESP_OKAY,   0, 1'b0, 0);
    vecs[1]  = mk(2'b11, 8'd1, 32'h0000_1100, 10'h022, 8'h0F, RESP_OKAY,   0, 1'b0, 1);
    vecs[2]  = mk(2'b11, 8'd2, 32'h0000_1200, 10'h033, 8'hFF, RESP_OKAY,   0, 1'b1, 0);
    vecs[3]  = mk(2'b11, 8'd0, 32'h0000_1300, 10'h044, 8'hAA, RESP_SLVERR, 0, 1'b0, 1);
    vecs[4]  = mk(2'b01, 8'd0, 32'h0000_1004, 10'h055, 8'hF0, RESP_OKAY,   0, 1'b0, 0);
    vecs[5]  = mk(2'b10, 8'd3, 32'h0000_1400, 10'h066, 8'hFF, RESP_OKAY,   0, 1'b1, 1);
    vecs[6]  = mk(2'b01, 8'd0, 32'h0000_1500, 10'h077, 8'h3C, RESP_SLVERR, 5, 1'b0, 0);
    vecs[7]  = mk(2'b11, 8'd0, 32'h0000_1600, 10'h088, 8'hFF, RESP_OKAY,   2, 1'b0, 1);
    vecs[8]  = mk(2'b01, 8'd3, 32'h0000_1700, 10'h099, 8'hFF, RESP_OKAY,   0, 1'b0, 0);
    vecs[9]  = mk(2'b11, 8'd0, 32'h0000_1800, 10'h0AA, 8'hFF, RESP_OKAY,   0, 1'b0, 0);
    vecs[10] = mk(2'b11, 8'd1, 32'h0000_1900, 10'h0BB, 8'h01, RESP_OKAY,   0, 1'b1, 1);
    vecs[11] = mk(2'b11, 8'd0, 32'h0000_1A00, 10'h0CC, 8'hFF, RESP_OKAY,   1, 1'b0, 0);
    vecs[12] = mk(2'b11, 8'd2, 32'h0000_1B00, 10'h0DD, 8'hFF, RESP_SLVERR, 0, 1'b0, 1);
    vecs[13] = mk(2'b01, 8'd0, 32'h0000_1C00, 10'h0EE, 8'h80, RESP_OKAY,   0, 1'b0, 0);
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    idle_inputs();
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    s_bready  = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_awvalid", {63'd0, m_awvalid}, 64'd0);
    chk("rst_m_wvalid", {63'd0, m_wvalid}, 64'd0);
    chk("rst_m_bready", {63'd0, m_bready}, 64'd0);
    chk("rst_s_awready", {62'd0, s_awready}, 64'd0);
    chk("rst_s_wready", {62'd0, s_wready}, 64'd0);
    chk("rst_s_bvalid", {62'd0, s_bvalid}, 64'd0);
    chk("rst_m_awaddr", {32'd0, m_awaddr}, 64'd0);
    idle_inputs();
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Abort a four-beat S0 burst after its first beat; priority was left at S1.
    s_awvalid[0] = 1'b1;
    s_awaddr[0]  = 32'h0000_2000;
    s_awlen[0]   = 8'd3;
    s_awid[0]    = 10'h3A5;
    step();
    m_awready = 1'b1;
    step();
    s_awvalid = '0;
    m_awready = 1'b0;
    s_wvalid[0] = 1'b1;
    s_wdata[0]  = 64'h1111_2222_3333_4444;
    m_wready    = 1'b1;
    step();
    chk("pre_rst_wvalid", {63'd0, m_wvalid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wvalid", {63'd0, m_wvalid}, 64'd0);
    chk("mid_rst_wdata", m_wdata, 64'd0);
    chk("mid_rst_s0_wready", {63'd0, s_wready[0]}, 64'd0);
    chk("mid_rst_awvalid", {63'd0, m_awvalid}, 64'd0);
    step();
    idle_inputs();
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    step();

    for (int i = 9; i < 14; i++) run_txn(vecs[i], i);

`ifdef MAILBOX_WRITE_ARBITER_PERF_EN
    chk("grant_cnt0", {32'd0, cnt0}, 64'(exp_cnt[0]));
    chk("grant_cnt1", {32'd0, cnt1}, 64'(exp_cnt[1]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mailbox_write_arbiter.md
Name: mailbox_write_arbiter

Overview:
- Shares the single AXI4 write slave port of the mailbox write adaptor between two AXI4 write masters: S0 (host side) and S1 (cluster side).
- Round-robin arbitration at transaction granularity. A grant is held from AW acceptance through all W beats to the B handshake.
- B responses are routed back to the granted master using the registered grant, so no ID extension is required.
- Sits directly upstream of the adaptor's AXI4 write port.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width.
- AXI_ID_WIDTH, 10, ID width (identical on all ports).
- AXI_USER_WIDTH, 6, B user width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width.

Ports:
(Sx_ denotes one port each for S0_ and S1_; M_ is the downstream port.)
- Clk_CI  in  1  clock
- Rst_RI  in  1  asynchronous active-high reset
- Sx_AwAddr_DI / M_AwAddr_DO  in/out  AXI_ADDR_WIDTH  write address
- Sx_AwLen_SI / M_AwLen_SO  in/out  8  burst length minus 1
- Sx_AwId_DI / M_AwId_DO  in/out  AXI_ID_WIDTH  write ID
- Sx_AwValid_SI / M_AwValid_SO  in/out  1  AW valid
- Sx_AwReady_SO / M_AwReady_SI  out/in  1  AW ready
- Sx_WData_DI / M_WData_DO  in/out  AXI_DATA_WIDTH  write data
- Sx_WStrb_DI / M_WStrb_DO  in/out  AXI_STRB_WIDTH  byte strobes
- Sx_WLast_SI / M_WLast_SO  in/out  1  last beat, forwarded unchanged
- Sx_WValid_SI / M_WValid_SO  in/out  1  W valid
- Sx_WReady_SO / M_WReady_SI  out/in  1  W ready
- Sx_BValid_SO / M_BValid_SI  out/in  1  B valid
- Sx_BReady_SI / M_BReady_SO  in/out  1  B ready
- Sx_BId_DO / M_BId_DI  out/in  AXI_ID_WIDTH  B ID
- Sx_BResp_DO / M_BResp_DI  out/in  2  B response
- Sx_BUser_DO / M_BUser_DI  out/in  AXI_USER_WIDTH  B user

Behaviour:
- Reset (async, on Rst_RI=1):
  - State=IDLE, Grant=0, Prio=0 (S0 preferred), BeatCnt=0.
  - All valid/ready outputs 0; all data outputs 0.
- FSM states: IDLE, AW, WRITE, RESP.
- IDLE:
  - No AwValid: stay.
  - One AwValid: register Grant to that master, go to AW.
  - Both AwValid: Grant=Prio, go to AW.
  - All Sx ready outputs are 0.
  - Grant decision is registered, so AW appears downstream one cycle after the request.
- AW:
  - M_Aw* is driven from Sx[Grant]. Sx_AwReady_SO[Grant] = M_AwReady_SI.
  - On handshake: BeatCnt=AwLen, go to WRITE.
- WRITE:
  - M_W* is driven from Sx[Grant]; Sx_WReady_SO[Grant] = M_WReady_SI.
  - On each W handshake: BeatCnt decrements. Handshake at BeatCnt==0 goes to RESP.
  - BeatCnt is authoritative; a WLast mismatch is not checked.
- RESP:
  - M_BReady_SO = Sx_BReady_SI[Grant]; Sx_BValid_SO[Grant] = M_BValid_SI.
  - BId/BResp/BUser pass through to the granted master.
  - On handshake: Prio = ~Grant, go to IDLE.
- Non-granted master: all its ready/valid outputs are 0 throughout. Its W beats issued before its AW is granted are held back, with no reordering.
- Data outputs (Sx_B*, M_*) are 0 whenever the matching valid is 0.
- Back-to-back transactions: IDLE lasts one cycle between transactions. With both masters continuously requesting, grants alternate S0, S1, S0, ...
- Reset mid-transaction aborts immediately. The downstream adaptor is reset by the same reset source.
- No combinational path from M_* ready to M_* valid.

Optional Feature:
- Macro: MAILBOX_WRITE_ARBITER_PERF_EN.
- Defined:
  - Adds output ports GrantCnt0_DO[31:0] and GrantCnt1_DO[31:0].
  - Each counts completed B handshakes per master, saturating at 0xFFFFFFFF.
  - Cleared only by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mailbox_write_arbiter_pkg:
  - State enum {IDLE, AW, WRITE, RESP}.
  - Master index type (1 bit).
  - Response constants OKAY=2'b00, SLVERR=2'b10.
- Sub-module mailbox_write_arbiter_rr: 2-way round-robin grant logic (requests, Prio in; grant out) plus the Prio register with an update strobe.

Test Plan:
- Single S0 write: AwLen=0, addr 0x1004, WStrb=0xF0 -> M_AwValid one cycle after S0_AwValid; one W beat forwarded; S0 gets BResp=0, BId equal to its AwId.
- Simultaneous AW, both masters: after reset -> S0 granted first, S1 second. Repeat -> S0, S1 alternate across 4 transactions; S1_WReady_SO stays 0 during S0's transaction.
- Burst: S1 AwLen=3, M_WReady toggling -> exactly 4 W beats forwarded; RESP entered after the 4th handshake; Sx_WLast_SI passed through unchanged.
- B backpressure: S0_BReady=0 for 5 cycles -> M_BReady_SO=0 and state holds RESP; the released handshake returns to IDLE.
- Reset asserted in WRITE after 1 of 4 beats -> all outputs 0 in the same cycle; state=IDLE and Prio=0 after release.
- With MAILBOX_WRITE_ARBITER_PERF_EN: 3 S0 and 2 S1 transactions -> GrantCnt0_DO=3, GrantCnt1_DO=2.
